// File: rtl/step_counter_reg_if.sv
// Control and data bundle for step_counter_reg.
// The master drives clr/ld/din/inc/dec; the slave returns q, cout and zero.
interface step_counter_reg_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] q;
    logic             cout;
    logic             zero;

    modport master (
        output clr, ld, din, inc, dec,
        input  q, cout, zero
    );

    modport slave (
        input  clr, ld, din, inc, dec,
        output q, cout, zero
    );
endinterface

// File: rtl/step_counter_reg.sv
// WIDTH-bit register: clear/load/count up or down by STEP, wrap or saturate. q and cout: 1 clk latency.
// No backpressure: an operation is accepted on every rising edge; zero follows q combinationally.
module step_counter_reg #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      STEP      = 1,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    step_counter_reg_if.slave  bus
);

    if (WIDTH < 2) begin : g_bad_width
        $error("step_counter_reg: WIDTH must be at least 2");
    end
    if ((64'(STEP) < 64'd1) || (64'(STEP) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_step
        $error("step_counter_reg: STEP must lie in 1 .. 2**WIDTH-1");
    end

    localparam logic [WIDTH:0]   STEP_EXT = STEP[WIDTH:0];
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] q_r;
    logic             cout_r;
    logic [WIDTH-1:0] q_nxt;
    logic             cout_nxt;

    // The extra MSB of sum/diff carries the overflow/borrow out of the WIDTH-bit range.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           ovf;
    logic           udf;

    assign sum  = {1'b0, q_r} + STEP_EXT;
    assign diff = {1'b0, q_r} - STEP_EXT;
    assign ovf  = sum[WIDTH];
    assign udf  = diff[WIDTH];

    always_comb begin
        q_nxt    = q_r;
        cout_nxt = 1'b0;
        if (bus.clr) begin
            q_nxt = '0;
        end else if (bus.ld) begin
            q_nxt = bus.din;
        end else if (bus.inc && !bus.dec) begin
            q_nxt    = (SATURATE && ovf) ? ALL_ONES : sum[WIDTH-1:0];
            cout_nxt = ovf;
        end else if (bus.dec && !bus.inc) begin
            q_nxt    = (SATURATE && udf) ? '0 : diff[WIDTH-1:0];
            cout_nxt = udf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r    <= RESET_VAL;
            cout_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            cout_r <= cout_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.cout = cout_r;
    assign bus.zero = (q_r == '0);

endmodule

// File: tb/tb_step_counter_reg.sv
// Drives four differently parameterised counters from one stimulus stream and checks them against an arithmetic model.
module tb_step_counter_reg;

    localparam int NDUT = 4;
    // Configurations: default wrap, saturating, 8-bit step 3, reset value 7.
    localparam int CW  [NDUT] = '{4, 4, 8, 4};
    localparam int CS  [NDUT] = '{1, 1, 3, 1};
    localparam int CSAT[NDUT] = '{0, 1, 0, 0};
    localparam int CRV [NDUT] = '{0, 0, 0, 7};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, ld, inc, dec;
    logic [7:0] din;

    int mq[NDUT];
    int mc[NDUT];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    step_counter_reg_if #(.WIDTH(4)) i0 ();
    step_counter_reg_if #(.WIDTH(4)) i1 ();
    step_counter_reg_if #(.WIDTH(8)) i2 ();
    step_counter_reg_if #(.WIDTH(4)) i3 ();

    assign i0.clr = clr; assign i0.ld = ld; assign i0.inc = inc; assign i0.dec = dec; assign i0.din = din[3:0];
    assign i1.clr = clr; assign i1.ld = ld; assign i1.inc = inc; assign i1.dec = dec; assign i1.din = din[3:0];
    assign i2.clr = clr; assign i2.ld = ld; assign i2.inc = inc; assign i2.dec = dec; assign i2.din = din;
    assign i3.clr = clr; assign i3.ld = ld; assign i3.inc = inc; assign i3.dec = dec; assign i3.din = din[3:0];

    step_counter_reg #(.WIDTH(4), .STEP(1), .SATURATE(1'b0), .RESET_VAL(4'd0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    step_counter_reg #(.WIDTH(4), .STEP(1), .SATURATE(1'b1), .RESET_VAL(4'd0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    step_counter_reg #(.WIDTH(8), .STEP(3), .SATURATE(1'b0), .RESET_VAL(8'd0)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
    step_counter_reg #(.WIDTH(4), .STEP(1), .SATURATE(1'b0), .RESET_VAL(4'd7)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));

    logic [7:0] q_obs[NDUT];
    logic       c_obs[NDUT];
    logic       z_obs[NDUT];
    assign q_obs[0] = 8'(i0.q); assign c_obs[0] = i0.cout; assign z_obs[0] = i0.zero;
    assign q_obs[1] = 8'(i1.q); assign c_obs[1] = i1.cout; assign z_obs[1] = i1.zero;
    assign q_obs[2] = i2.q;     assign c_obs[2] = i2.cout; assign z_obs[2] = i2.zero;
    assign q_obs[3] = 8'(i3.q); assign c_obs[3] = i3.cout; assign z_obs[3] = i3.zero;

    // Reference: apply the priority rules to integer values, range = 0 .. 2**W-1.
    task automatic step_models();
        for (int k = 0; k < NDUT; k++) begin
            int top;
            int t;
            top = (1 << CW[k]) - 1;
            if (!rst_n) begin
                mq[k] = CRV[k]; mc[k] = 0;
            end else if (clr) begin
                mq[k] = 0; mc[k] = 0;
            end else if (ld) begin
                mq[k] = int'(din) % (top + 1); mc[k] = 0;
            end else if (inc && !dec) begin
                t = mq[k] + CS[k];
                mc[k] = (t > top) ? 1 : 0;
                mq[k] = (t > top) ? (CSAT[k] != 0 ? top : t - (top + 1)) : t;
            end else if (dec && !inc) begin
                t = mq[k] - CS[k];
                mc[k] = (t < 0) ? 1 : 0;
                mq[k] = (t < 0) ? (CSAT[k] != 0 ? 0 : t + (top + 1)) : t;
            end else begin
                mc[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            assert (q_obs[k] === 8'(mq[k])) else begin
                n_fail++;
                $error("FAIL %s q dut%0d got %0d want %0d", tag, k, q_obs[k], mq[k]);
            end
            n_checks++;
            assert (c_obs[k] === 1'(mc[k])) else begin
                n_fail++;
                $error("FAIL %s cout dut%0d got %b want %0d", tag, k, c_obs[k], mc[k]);
            end
            n_checks++;
            assert (z_obs[k] === (mq[k] == 0)) else begin
                n_fail++;
                $error("FAIL %s zero dut%0d got %b want %b", tag, k, z_obs[k], (mq[k] == 0));
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        step_models();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input logic [7:0] d,
                         input logic i, input logic de);
        rst_n = r; clr = c; ld = l; din = d; inc = i; dec = de;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            mq[k] = 0; mc[k] = 0;
        end
        drive(1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
        @(negedge clk);

        // Reset overrides load and increment.
        cycle("reset1");
        cycle("reset2");
        check_val("reset_q0", q_obs[0], 8'd0);
        check_val("reset_zero0", 8'(z_obs[0]), 8'd1);
        check_val("reset_q3", q_obs[3], 8'd7);

        // Wrap through full range, then borrow from zero.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int n = 0; n < 16; n++) cycle("inc_wrap");
        check_val("wrap_q0", q_obs[0], 8'd0);
        check_val("wrap_cout0", 8'(c_obs[0]), 8'd1);
        check_val("sat_q1", q_obs[1], 8'd15);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        cycle("dec_borrow");
        check_val("borrow_q0", q_obs[0], 8'd15);

        // Saturating clamp with repeated cout.
        drive(1'b1, 1'b0, 1'b1, 8'd14, 1'b0, 1'b0);
        cycle("ld14");
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) cycle("sat_inc");
        check_val("sat_cout1", 8'(c_obs[1]), 8'd1);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        cycle("clr");
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        cycle("sat_dec");
        check_val("sat_dec_q1", q_obs[1], 8'd0);

        // Priority.
        drive(1'b1, 1'b1, 1'b1, 8'd9, 1'b1, 1'b0);
        cycle("prio_clr");
        drive(1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 1'b0);
        cycle("prio_ld");
        check_val("prio_ld_q0", q_obs[0], 8'd9);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        cycle("prio_incdec");
        drive(1'b1, 1'b0, 1'b1, 8'd15, 1'b0, 1'b0);
        cycle("ld15");
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        cycle("ovf");
        drive(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        cycle("ld_drops_cout");

        // 8-bit step-3 boundaries.
        drive(1'b1, 1'b0, 1'b1, 8'd254, 1'b0, 1'b0); cycle("ld254");
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);   cycle("w8_inc");
        check_val("w8_inc_q2", q_obs[2], 8'd1);
        drive(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);   cycle("ld2");
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);   cycle("w8_dec");
        check_val("w8_dec_q2", q_obs[2], 8'd255);
        drive(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);   cycle("ld3");
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);   cycle("w8_exact");
        check_val("w8_exact_q2", q_obs[2], 8'd0);

        // Reset mid-count returns to RESET_VAL.
        drive(1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 1'b0); cycle("ld10");
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);  cycle("mid_reset");
        check_val("mid_reset_q3", q_obs[3], 8'd7);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);  cycle("after_reset");
        check_val("after_reset_q3", q_obs[3], 8'd8);

        // Randomised operation mix.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 5) == 0), 8'($urandom),
                  1'($urandom), 1'($urandom));
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
